// File: rtl/mmio_button_debouncer_if.sv
// Button/MMIO signal bundle between the debouncer and the core's MMIO input port 4.
// master = core/wrapper side, slave = mmio_button_debouncer.
interface mmio_button_debouncer_if #(
    parameter int NUM_BUTTONS = 4
);
    logic [NUM_BUTTONS-1:0] rawButton;
    logic [NUM_BUTTONS-1:0] clearEvents;
    logic [31:0]            mmioWord;
    logic [NUM_BUTTONS-1:0] pressPulse;
    logic                   anyEvent;

    modport master (
        output rawButton,
        output clearEvents,
        input  mmioWord,
        input  pressPulse,
        input  anyEvent
    );

    modport slave (
        input  rawButton,
        input  clearEvents,
        output mmioWord,
        output pressPulse,
        output anyEvent
    );
endinterface

// File: rtl/mmio_button_debouncer.sv
// Synchronizes and debounces devboard buttons and packs levels plus sticky edge flags into one MMIO word.
// Optional release-event flags are enabled by defining MMIO_BUTTON_RELEASE_EVENT_EN.
module mmio_button_debouncer #(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                    clock,
    input  logic                    reset,
    mmio_button_debouncer_if.slave  bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] IDLE_LOW   = 2'b00;
    localparam logic [1:0] CHECK_HIGH = 2'b01;
    localparam logic [1:0] IDLE_HIGH  = 2'b10;
    localparam logic [1:0] CHECK_LOW  = 2'b11;

    logic [NUM_BUTTONS-1:0] sync1_r;
    logic [NUM_BUTTONS-1:0] sync2_r;
    logic [1:0]             state_r [NUM_BUTTONS];
    logic [1:0]             state_s [NUM_BUTTONS];
    logic [CNT_W-1:0]       cnt_r   [NUM_BUTTONS];
    logic [CNT_W-1:0]       cnt_s   [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] stable_s;
    logic [NUM_BUTTONS-1:0] press_set_s;
    logic [NUM_BUTTONS-1:0] press_flag_r;
    logic [NUM_BUTTONS-1:0] press_flag_s;
`ifdef MMIO_BUTTON_RELEASE_EVENT_EN
    logic [NUM_BUTTONS-1:0] release_set_s;
    logic [NUM_BUTTONS-1:0] release_flag_r;
    logic [NUM_BUTTONS-1:0] release_flag_s;
`endif
    logic [31:0]            word_s;
    logic                   any_s;
    logic [31:0]            mmio_word_r;
    logic [NUM_BUTTONS-1:0] press_pulse_r;
    logic                   any_event_r;

    // Per-button debounce FSM: a level is accepted only after DEBOUNCE_CYCLES identical samples.
    always_comb begin
        press_set_s = {NUM_BUTTONS{1'b0}};
        stable_s    = {NUM_BUTTONS{1'b0}};
`ifdef MMIO_BUTTON_RELEASE_EVENT_EN
        release_set_s = {NUM_BUTTONS{1'b0}};
`endif
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            state_s[i] = state_r[i];
            cnt_s[i]   = cnt_r[i];
            case (state_r[i])
                IDLE_LOW: begin
                    if (sync2_r[i]) begin
                        state_s[i] = CHECK_HIGH;
                        cnt_s[i]   = CNT_W'(1);
                    end else begin
                        cnt_s[i]   = CNT_W'(0);
                    end
                end
                CHECK_HIGH: begin
                    if (!sync2_r[i]) begin
                        state_s[i] = IDLE_LOW;
                        cnt_s[i]   = CNT_W'(0);
                    end else if (cnt_r[i] == CNT_LAST) begin
                        state_s[i]     = IDLE_HIGH;
                        cnt_s[i]       = CNT_W'(0);
                        press_set_s[i] = 1'b1;
                    end else begin
                        cnt_s[i]   = cnt_r[i] + CNT_W'(1);
                    end
                end
                IDLE_HIGH: begin
                    if (!sync2_r[i]) begin
                        state_s[i] = CHECK_LOW;
                        cnt_s[i]   = CNT_W'(1);
                    end else begin
                        cnt_s[i]   = CNT_W'(0);
                    end
                end
                CHECK_LOW: begin
                    if (sync2_r[i]) begin
                        state_s[i] = IDLE_HIGH;
                        cnt_s[i]   = CNT_W'(0);
                    end else if (cnt_r[i] == CNT_LAST) begin
                        state_s[i] = IDLE_LOW;
                        cnt_s[i]   = CNT_W'(0);
`ifdef MMIO_BUTTON_RELEASE_EVENT_EN
                        release_set_s[i] = 1'b1;
`endif
                    end else begin
                        cnt_s[i]   = cnt_r[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_s[i] = IDLE_LOW;
                    cnt_s[i]   = CNT_W'(0);
                end
            endcase
            stable_s[i] = (state_s[i] == IDLE_HIGH) || (state_s[i] == CHECK_LOW);
        end
    end

    // Sticky flags (set beats clear so no event is lost) and the packed output word.
    always_comb begin
        press_flag_s = press_set_s | (press_flag_r & ~bus.clearEvents);
        word_s       = 32'h0000_0000;
        word_s[NUM_BUTTONS-1:0]  = stable_s;
        word_s[8 +: NUM_BUTTONS] = press_flag_s;
`ifdef MMIO_BUTTON_RELEASE_EVENT_EN
        release_flag_s = release_set_s | (release_flag_r & ~bus.clearEvents);
        word_s[16 +: NUM_BUTTONS] = release_flag_s;
        any_s = (|press_flag_s) | (|release_flag_s);
`else
        any_s = |press_flag_s;
`endif
    end

    // State, synchronizer and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r       <= {NUM_BUTTONS{1'b0}};
            sync2_r       <= {NUM_BUTTONS{1'b0}};
            press_flag_r  <= {NUM_BUTTONS{1'b0}};
            press_pulse_r <= {NUM_BUTTONS{1'b0}};
            mmio_word_r   <= 32'h0000_0000;
            any_event_r   <= 1'b0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                state_r[i] <= IDLE_LOW;
                cnt_r[i]   <= CNT_W'(0);
            end
`ifdef MMIO_BUTTON_RELEASE_EVENT_EN
            release_flag_r <= {NUM_BUTTONS{1'b0}};
`endif
        end else begin
            sync1_r       <= bus.rawButton;
            sync2_r       <= sync1_r;
            press_flag_r  <= press_flag_s;
            press_pulse_r <= press_set_s;
            mmio_word_r   <= word_s;
            any_event_r   <= any_s;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                state_r[i] <= state_s[i];
                cnt_r[i]   <= cnt_s[i];
            end
`ifdef MMIO_BUTTON_RELEASE_EVENT_EN
            release_flag_r <= release_flag_s;
`endif
        end
    end

    assign bus.mmioWord   = mmio_word_r;
    assign bus.pressPulse = press_pulse_r;
    assign bus.anyEvent   = any_event_r;
endmodule
